// File: rtl/qdec_cabac_bin_arbiter.sv
// Round-robin owner arbiter that shares one CABAC bin decoder engine among
// NUM_REQ syntax sub-FSMs and steers decoded bins back to the current owner only.
module qdec_cabac_bin_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    input  logic [NUM_REQ*10-1:0] ctx_addr_in,
    input  logic [NUM_REQ-1:0]    ctx_addr_vld_in,
    input  logic [NUM_REQ-1:0]    dec_run_in,
    input  logic [NUM_REQ-1:0]    EPMode_in,
    output logic [9:0]            ctx_addr,
    output logic                  ctx_addr_vld,
    output logic                  dec_run,
    output logic                  EPMode,
    input  logic                  dec_rdy,
    input  logic                  ruiBin,
    input  logic                  ruiBin_vld,
    output logic [NUM_REQ-1:0]    ruiBin_vld_out,
    output logic                  busy,
    output logic                  err
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0]   owner_reg, owner_next;
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]   out_cnt_reg, out_cnt_next;
    logic               err_reg, err_next;

    logic [9:0]         ctx_masked [NUM_REQ];
    logic               owner_run, at_max, cnt_zero, bin_ok, overflow;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx, cand, owner_plus1;

    // dec_rdy and ruiBin go straight from the engine to every requester.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, dec_rdy, ruiBin};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign ctx_masked[gi] = ctx_addr_in[10*gi +: 10] & {10{gnt_reg[gi]}};
        end
    endgenerate

    always_comb begin
        ctx_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ctx_addr = ctx_addr | ctx_masked[i];
        end
    end

    assign ctx_addr_vld   = |(ctx_addr_vld_in & gnt_reg);
    assign EPMode         = |(EPMode_in & gnt_reg);
    assign owner_run      = |(dec_run_in & gnt_reg);
    assign at_max         = (out_cnt_reg == CNT_W'(MAX_OUT));
    assign cnt_zero       = (out_cnt_reg == '0);
    assign dec_run        = owner_run && (state_reg == ST_OWN) && !at_max;
    assign overflow       = owner_run && (state_reg == ST_OWN) && at_max;
    assign bin_ok         = ruiBin_vld && !cnt_zero;
    assign ruiBin_vld_out = gnt_reg & {NUM_REQ{bin_ok}};
    assign gnt            = gnt_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign err            = err_reg;
    assign owner_plus1    = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;

    always_comb begin
        out_cnt_next = out_cnt_reg;
        case ({dec_run, bin_ok})
            2'b10:   out_cnt_next = out_cnt_reg + 1'b1;
            2'b01:   out_cnt_next = out_cnt_reg - 1'b1;
            default: out_cnt_next = out_cnt_reg;
        endcase
        err_next = err_reg | overflow | (ruiBin_vld && cnt_zero);
    end

    // First pending request at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Release decisions look at the post-update count so a bin that returns
    // or a run issued in the release cycle is never orphaned.
    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    state_next = ST_OWN;
                    gnt_next   = NUM_REQ'(1) << pick_idx;
                    owner_next = pick_idx;
                end
            end
            ST_OWN: begin
                if (!req[owner_reg]) begin
                    if (out_cnt_next == '0) begin
                        state_next  = ST_IDLE;
                        gnt_next    = '0;
                        rr_ptr_next = owner_plus1;
                    end else begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_cnt_next == '0) begin
                    state_next  = ST_IDLE;
                    gnt_next    = '0;
                    rr_ptr_next = owner_plus1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= '0;
            owner_reg   <= '0;
            rr_ptr_reg  <= '0;
            out_cnt_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            owner_reg   <= owner_next;
            rr_ptr_reg  <= rr_ptr_next;
            out_cnt_reg <= out_cnt_next;
            err_reg     <= err_next;
        end
    end
endmodule

// File: tb/tb_qdec_cabac_bin_arbiter.sv
// Randomized and directed scoreboard bench for qdec_cabac_bin_arbiter.
module tb_qdec_cabac_bin_arbiter;
    localparam int NUM_REQ = 4;
    localparam int MAX_OUT = 4;
    localparam int CNT_W   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, gnt, ctx_addr_vld_in, dec_run_in, EPMode_in, ruiBin_vld_out;
    logic [39:0] ctx_addr_in;
    logic [9:0]  ctx_addr;
    logic        ctx_addr_vld, dec_run, EPMode, dec_rdy, ruiBin, ruiBin_vld, busy, err;

    always #5 clk = ~clk;

    qdec_cabac_bin_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .ctx_addr_in(ctx_addr_in), .ctx_addr_vld_in(ctx_addr_vld_in),
        .dec_run_in(dec_run_in), .EPMode_in(EPMode_in),
        .ctx_addr(ctx_addr), .ctx_addr_vld(ctx_addr_vld), .dec_run(dec_run), .EPMode(EPMode),
        .dec_rdy(dec_rdy), .ruiBin(ruiBin), .ruiBin_vld(ruiBin_vld),
        .ruiBin_vld_out(ruiBin_vld_out), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic       dec_run;
        logic [3:0] bout;
        logic [9:0] ctx_addr;
        logic       ctx_vld;
        logic       ep;
        logic       err;
        logic       busy;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         txn = 0;
    logic [3:0] mon_prev_gnt = 4'b0;

    // Reference model: 0 = no owner, 1 = owner active, 2 = owner draining.
    int         m_st, m_own, m_rr, m_cnt;
    bit         m_err;
    logic [3:0] m_last_gnt;

    task automatic model_reset();
        m_st = 0; m_own = 0; m_rr = 0; m_cnt = 0; m_err = 0; m_last_gnt = 4'b0;
        exp_q.delete();
    endtask

    task automatic model_cycle();
        exp_t e;
        bit   want, ovf, bin_ok, found;
        int   cnt_before, nxt;
        e.gnt      = (m_st != 0) ? 4'(1 << m_own) : 4'b0;
        e.ctx_addr = (m_st != 0) ? ctx_addr_in[10*m_own +: 10] : 10'd0;
        e.ctx_vld  = (m_st != 0) && ctx_addr_vld_in[m_own];
        e.ep       = (m_st != 0) && EPMode_in[m_own];
        want       = (m_st != 0) && dec_run_in[m_own];
        e.dec_run  = (m_st == 1) && want && (m_cnt < MAX_OUT);
        ovf        = (m_st == 1) && want && (m_cnt == MAX_OUT);
        bin_ok     = ruiBin_vld && (m_cnt > 0);
        e.bout     = bin_ok ? e.gnt : 4'b0;
        e.err      = m_err;
        e.busy     = (m_st != 0);
        if (e.dec_run || e.bout != 4'b0 || e.gnt != m_last_gnt) begin
            exp_q.push_back(e);
            m_last_gnt = e.gnt;
        end
        m_err      = m_err || ovf || (ruiBin_vld && m_cnt == 0);
        cnt_before = m_cnt;
        m_cnt      = m_cnt + int'(e.dec_run) - int'(bin_ok);
        case (m_st)
            0: begin
                found = 0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    nxt = (m_rr + k) % NUM_REQ;
                    if (!found && req[nxt]) begin
                        found = 1; m_own = nxt; m_st = 1;
                    end
                end
            end
            1: if (!req[m_own]) begin
                if (cnt_before == 0) begin m_st = 0; m_rr = (m_own + 1) % NUM_REQ; end
                else m_st = 2;
            end
            default: if (m_cnt == 0) begin m_st = 0; m_rr = (m_own + 1) % NUM_REQ; end
        endcase
    endtask

    always @(negedge clk) begin
        exp_t e, a;
        if (rst) begin
            mon_prev_gnt = 4'b0;
        end else if (dec_run || ruiBin_vld_out != 4'b0 || gnt != mon_prev_gnt) begin
            mon_prev_gnt = gnt;
            a.gnt = gnt; a.dec_run = dec_run; a.bout = ruiBin_vld_out; a.ctx_addr = ctx_addr;
            a.ctx_vld = ctx_addr_vld; a.ep = EPMode; a.err = err; a.busy = busy;
            checks++;
            txn++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got gnt=%b dec_run=%b bin_out=%b, required no activity",
                         gnt, dec_run, ruiBin_vld_out);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL sb_txn %0d: got gnt=%b run=%b bout=%b ctx=%h vld=%b ep=%b err=%b busy=%b, required gnt=%b run=%b bout=%b ctx=%h vld=%b ep=%b err=%b busy=%b",
                             txn, a.gnt, a.dec_run, a.bout, a.ctx_addr, a.ctx_vld, a.ep, a.err, a.busy,
                             e.gnt, e.dec_run, e.bout, e.ctx_addr, e.ctx_vld, e.ep, e.err, e.busy);
                end else begin
                    $display("txn %0d gnt=%b dec_run=%b bin_out=%b ctx=%h err=%b ok",
                             txn, a.gnt, a.dec_run, a.bout, a.ctx_addr, a.err);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    task automatic step();
        ruiBin  = 1'($urandom);
        dec_rdy = 1'($urandom);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] dr, input logic bv);
        req             = r;
        dec_run_in      = dr;
        ruiBin_vld      = bv;
        ctx_addr_vld_in = 4'($urandom);
        EPMode_in       = 4'($urandom);
        ctx_addr_in     = 40'({$urandom(), $urandom()});
        step();
    endtask

    task automatic reset_sync();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_cycle(input bit err_en);
        logic [3:0] r, dr;
        logic       bv;
        bit         drop;
        r    = req;
        dr   = 4'($urandom);
        drop = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_st == 1 && i == m_own) begin
                if ($urandom_range(0, 7) == 0) begin r[i] = 1'b0; drop = 1; end
            end else if (r[i]) begin
                if ($urandom_range(0, 9) == 0) r[i] = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                r[i] = 1'b1;
            end
        end
        if (!err_en && m_st == 1 && m_cnt == MAX_OUT) dr[m_own] = 1'b0;
        bv = (m_cnt > 0) ? ($urandom_range(0, 2) != 0) : (err_en && $urandom_range(0, 15) == 0);
        // Release cycles carry no run or bin so the release rule is unambiguous.
        if (drop) begin dr[m_own] = 1'b0; bv = 1'b0; end
        drive(r, dr, bv);
    endtask

    task automatic drain_all();
        drive(4'b0000, 4'b0000, 1'b0);
        for (int i = 0; i < 20; i++) drive(4'b0000, 4'b0000, m_cnt > 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; ctx_addr_in = '0; ctx_addr_vld_in = '0; dec_run_in = '0;
        EPMode_in = '0; dec_rdy = 1'b0; ruiBin = 1'b0; ruiBin_vld = 1'b0;
        model_reset();
        #2;
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_dec_run", 32'(dec_run), 0);
        chk("reset_ctx_addr", 32'(ctx_addr), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester on index 2.
        drive(4'b0100, 4'b0000, 1'b0);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_busy", 32'(busy), 1);
        repeat (3) drive(4'b0100, 4'b1111, 1'b0);
        repeat (3) drive(4'b0100, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0);
        chk("single_release_gnt", 32'(gnt), 0);
        chk("single_release_busy", 32'(busy), 0);
        drive(4'b1010, 4'b0000, 1'b0);
        chk("rr_after_2_gnt", 32'(gnt), 32'h8);
        drive(4'b0000, 4'b0000, 1'b0);

        // Round robin with all requesters pending.
        for (int n = 0; n < 5; n++) begin
            int o;
            o = n % NUM_REQ;
            drive(4'b1111, 4'b0000, 1'b0);
            chk($sformatf("rr_gnt_%0d", n), 32'(gnt), 32'(1 << o));
            drive(4'b1111, 4'(1 << o), 1'b0);
            drive(4'b1111, 4'b0000, 1'b1);
            drive(4'b1111 & ~4'(1 << o), 4'b0000, 1'b0);
            chk($sformatf("rr_bubble_%0d", n), 32'(gnt), 0);
        end

        // Drain: owner 1 releases with two bins in flight, requester 3 waits.
        drive(4'b1010, 4'b0000, 1'b0);
        chk("drain_gnt", 32'(gnt), 32'h2);
        repeat (2) drive(4'b1010, 4'b0010, 1'b0);
        drive(4'b1000, 4'b0000, 1'b0);
        drive(4'b1000, 4'b0010, 1'b0);
        chk("drain_gnt_held", 32'(gnt), 32'h2);
        chk("drain_busy", 32'(busy), 1);
        drive(4'b1000, 4'b0010, 1'b1);
        drive(4'b1000, 4'b0010, 1'b1);
        chk("drain_done_gnt", 32'(gnt), 0);
        drive(4'b1000, 4'b0000, 1'b0);
        chk("drain_next_gnt", 32'(gnt), 32'h8);

        // Simultaneous increment and decrement.
        drive(4'b1000, 4'b1000, 1'b0);
        drive(4'b1000, 4'b1000, 1'b1);
        drive(4'b1000, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0);
        chk("incdec_err", 32'(err), 0);
        chk("incdec_release_gnt", 32'(gnt), 0);

        for (int i = 0; i < 600; i++) rand_cycle(1'b0);
        drain_all();
        chk("rand_clean_err", 32'(err), 0);
        chk("rand_clean_busy", 32'(busy), 0);

        // Overflow: fifth run at MAX_OUT outstanding.
        drive(4'b0001, 4'b0000, 1'b0);
        repeat (5) drive(4'b0001, 4'b0001, 1'b0);
        chk("overflow_err", 32'(err), 1);
        repeat (4) drive(4'b0001, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0);
        chk("overflow_err_sticky", 32'(err), 1);
        chk("overflow_release_gnt", 32'(gnt), 0);
        reset_sync();
        chk("err_cleared_by_rst", 32'(err), 0);

        // Asynchronous reset in the middle of ownership with three bins in flight.
        drive(4'b0001, 4'b0000, 1'b0);
        repeat (3) drive(4'b0001, 4'b0001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_dec_run", 32'(dec_run), 0);
        chk("async_ctx_vld", 32'(ctx_addr_vld), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(4'b0001, 4'b0000, 1'b1);
        chk("late_bin_err", 32'(err), 1);
        chk("post_reset_gnt", 32'(gnt), 32'h1);
        drive(4'b0001, 4'b0000, 1'b1);
        drive(4'b0000, 4'b0000, 1'b0);

        reset_sync();
        for (int i = 0; i < 600; i++) rand_cycle(1'b1);
        drain_all();
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected events, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/qdec_cabac_bin_arbiter.md
Name: qdec_cabac_bin_arbiter

Overview:
- Shares the single CABAC bin decoder engine among NUM_REQ syntax sub-FSMs, e.g. SAO, CU, PU and TU.
- Each sub-FSM drives its own ctx address, ctx-valid, run and EP-mode. The arbiter grants exactly one owner at a time and muxes that owner's controls to the engine.
- Decoded bins are steered back to the owner only.
- Ownership changes only when no bins are in flight, so a sub-FSM's bin counters are never corrupted by another requester's bins.

Parameters:
- NUM_REQ, 4, number of requesting sub-FSMs. Index 0 has the highest initial round-robin priority.
- MAX_OUT, 4, maximum dec_run pulses outstanding without a returned ruiBin_vld.
- CNT_W, 3, outstanding-counter width. Must satisfy 2^CNT_W > MAX_OUT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req  in  NUM_REQ  level request per sub-FSM; held high for the whole syntax-element group
- gnt  out  NUM_REQ  one-hot grant, registered
- ctx_addr_in  in  NUM_REQ*10  packed ctx addresses; slice i = bits [10i+9:10i]
- ctx_addr_vld_in  in  NUM_REQ  ctx address valid per requester
- dec_run_in  in  NUM_REQ  decode-run pulse per requester
- EPMode_in  in  NUM_REQ  bypass-mode select per requester
- ctx_addr  out  10  to context memory
- ctx_addr_vld  out  1  to context memory
- dec_run  out  1  to bin decoder engine
- EPMode  out  1  to bin decoder engine
- dec_rdy  in  1  engine ready (informational; passed through unchanged to all requesters)
- ruiBin  in  1  decoded bin, broadcast to all requesters
- ruiBin_vld  in  1  decoded bin valid
- ruiBin_vld_out  out  NUM_REQ  bin valid gated to the owner only
- busy  out  1  high when state is not IDLE
- err  out  1  sticky protocol error; cleared only by rst

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, gnt=0, rr_ptr=0, outstanding=0, err=0.
  - With gnt=0, ctx_addr=0, ctx_addr_vld=0, dec_run=0, EPMode=0, ruiBin_vld_out=0, busy=0.
- Output muxing: ctx_addr, ctx_addr_vld, dec_run and EPMode are combinational from the registered gnt: they equal the owner's inputs ANDed with gnt. No added latency.
  - ruiBin_vld_out[i] = ruiBin_vld & gnt[i].
- States:
  - IDLE: if any req, pick the first set req at or after rr_ptr (wrapping). Next cycle gnt is one-hot for it; go to OWN. Request-to-grant latency is 1 cycle.
  - OWN: pass through while req[owner]=1. When req[owner] falls: go to IDLE if outstanding==0, else go to DRAIN.
  - DRAIN: gnt held, dec_run forced 0. Go to IDLE when outstanding reaches 0, counting a decrement in the current cycle.
  - Leaving OWN or DRAIN: gnt<=0 and rr_ptr<=owner+1 (mod NUM_REQ). The next grant can follow one IDLE cycle later, giving a 1-cycle bubble between owners.
- Outstanding counter:
  - +1 on dec_run out; -1 on ruiBin_vld. Both in the same cycle leaves it unchanged.
  - If outstanding==MAX_OUT and the owner asserts dec_run: dec_run out is suppressed, the count does not change, and err is set.
  - If ruiBin_vld arrives with outstanding==0: the bin is dropped (no ruiBin_vld_out), the count stays 0, and err is set.
- Simultaneous events:
  - A request arriving in the same cycle the owner releases waits for IDLE.
  - If req[owner] re-asserts during DRAIN it is ignored until the next IDLE, where round-robin may grant it only if no other requester is pending.
- Activity while not granted: ctx_addr_vld_in, dec_run_in or EPMode_in from a non-granted requester are ignored and do not set err.
- Reset mid-operation: everything returns to reset values immediately. In-flight bins returning after reset hit the outstanding==0 rule and set err.
- busy=1 in OWN and DRAIN.

Test Plan:
- Single requester: req[2]=1, three dec_run pulses, three ruiBin_vld → gnt=4'b0100 one cycle after req, dec_run out ×3, ruiBin_vld_out[2] ×3, others 0. Drop req → IDLE next cycle, rr_ptr=3.
- Round-robin: req=4'b1111 held, each owner issues one bin then drops → grant order 0,1,2,3,0 with one IDLE bubble between owners.
- Drain: owner drops req with outstanding=2 → state DRAIN, dec_run out stays 0 despite dec_run_in, gnt held. After the second ruiBin_vld → IDLE; the next requester is granted 2 cycles later.
- Simultaneous inc/dec: dec_run and ruiBin_vld in the same cycle with outstanding=1 → outstanding stays 1, err=0.
- Errors: ruiBin_vld with outstanding=0 → err=1, no ruiBin_vld_out. A fifth dec_run at outstanding=4 → suppressed, err=1. err remains 1 until rst.
- Async reset: assert rst during OWN with outstanding=3 → gnt=0, busy=0, outputs 0 without waiting for a clock edge. After release, state is IDLE and the first request is granted normally.
